// File: rtl/pixel_frame_loader_pkg.sv
// Shared constants and state encoding for the serial 3x3 binary pixel path.
package pixel_frame_loader_pkg;
  localparam int N_PIX = 9;
  localparam int IDX_W = 4;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PIX - 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(N_PIX);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;
endpackage

// File: rtl/pixel_frame_loader.sv
// Collects a serial 3x3 binary frame into a fill buffer and hands it to a
// held output register with a valid/ack handshake toward the consumer.
module pixel_frame_loader
  import pixel_frame_loader_pkg::*;
#(
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pix_in,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  output logic                   pix_ready,
  output logic                   X_0,
  output logic                   X_1,
  output logic                   X_2,
  output logic                   X_3,
  output logic                   X_4,
  output logic                   X_5,
  output logic                   X_6,
  output logic                   X_7,
  output logic                   X_8,
  output logic                   frame_valid,
  input  logic                   frame_ack,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   sync_err
);

  state_t             state;
  logic [N_PIX-1:0]   fill_buf;
  logic [N_PIX-1:0]   fill_next;
  logic [N_PIX-1:0]   out_reg;
  logic [IDX_W-1:0]   idx;
  logic               accept;

  assign pix_ready = (state == S_FILL);
  assign accept    = pix_valid && pix_ready;

  // Completed frame as it will look once the 9th pixel lands.
  always_comb begin
    fill_next            = fill_buf;
    fill_next[N_PIX-1]   = pix_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FILL;
      fill_buf    <= '0;
      out_reg     <= '0;
      idx         <= '0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      sync_err    <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      case (state)
        S_FILL: begin
          // Consumption without a transfer empties the output; a transfer below overrides.
          if (frame_valid && frame_ack) frame_valid <= 1'b0;
          if (accept) begin
            if (pix_sof) begin
              fill_buf[0] <= pix_in;
              idx         <= IDX_W'(1);
              if (idx != '0) sync_err <= 1'b1;
            end else if (idx == '0) begin
              sync_err <= 1'b1;
            end else if (idx == IDX_LAST) begin
              fill_buf <= fill_next;
              if (!frame_valid || frame_ack) begin
                out_reg     <= fill_next;
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 1'b1;
                idx         <= '0;
              end else begin
                idx   <= IDX_FULL;
                state <= S_FULL;
              end
            end else begin
              fill_buf[idx] <= pix_in;
              idx           <= idx + 1'b1;
            end
          end
        end
        S_FULL: begin
          // frame_valid is necessarily set here, so the ack always drains into a transfer.
          if (frame_ack) begin
            out_reg   <= fill_buf;
            frame_cnt <= frame_cnt + 1'b1;
            idx       <= '0;
            state     <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  assign {X_8, X_7, X_6, X_5, X_4, X_3, X_2, X_1, X_0} = out_reg;

endmodule

// File: tb/tb_pixel_frame_loader.sv
// Directed vector table plus hand sequences for the 3x3 pixel frame loader.
module tb_pixel_frame_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_in, pix_valid, pix_sof, frame_ack;
  logic       pix_ready, frame_valid, sync_err;
  logic       X_0, X_1, X_2, X_3, X_4, X_5, X_6, X_7, X_8;
  logic [7:0] frame_cnt;
  logic [8:0] xv;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign xv = {X_8, X_7, X_6, X_5, X_4, X_3, X_2, X_1, X_0};

  pixel_frame_loader #(.FRAME_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_ready(pix_ready),
    .X_0(X_0), .X_1(X_1), .X_2(X_2), .X_3(X_3), .X_4(X_4),
    .X_5(X_5), .X_6(X_6), .X_7(X_7), .X_8(X_8),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .frame_cnt(frame_cnt), .sync_err(sync_err)
  );

  typedef struct {
    logic       v, s, p, a;
    logic [8:0] x;
    logic       fv, rdy, err;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  task automatic add(input logic v, s, p, a, input logic [8:0] x,
                     input logic fv, rdy, err, input logic [7:0] cnt);
    vec_t t;
    t.v = v; t.s = s; t.p = p; t.a = a; t.x = x;
    t.fv = fv; t.rdy = rdy; t.err = err; t.cnt = cnt;
    vecs.push_back(t);
  endtask

  task automatic beat(input logic v, s, p, a);
    pix_valid = v; pix_sof = s; pix_in = p; frame_ack = a;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [8:0] pat, input logic a);
    for (int k = 0; k < 9; k++) beat(1'b1, k == 0, pat[k], a);
  endtask

  task automatic do_reset();
    pix_valid = 0; pix_sof = 0; pix_in = 0; frame_ack = 0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [8:0] pa, pb, pc, pat;

    // Frame A: 1,0,1,0,1,0,1,0,1 with ack low.
    pa = 9'b101010101;
    for (int k = 0; k < 8; k++) add(1, k == 0, pa[k], 0, 9'h000, 0, 1, 0, 8'd0);
    add(1, 0, pa[8], 0, 9'h155, 1, 1, 0, 8'd1);
    // Frame B: all ones while A is held -> stalls in FULL.
    for (int k = 0; k < 8; k++) add(1, k == 0, 1, 0, 9'h155, 1, 1, 0, 8'd1);
    add(1, 0, 1, 0, 9'h155, 1, 0, 0, 8'd1);
    add(1, 0, 0, 0, 9'h155, 1, 0, 0, 8'd1);
    add(0, 0, 0, 1, 9'h1FF, 1, 1, 0, 8'd2);
    add(0, 0, 0, 1, 9'h1FF, 0, 1, 0, 8'd2);
    add(0, 0, 0, 1, 9'h1FF, 0, 1, 0, 8'd2);
    // Partial frame of 4 pixels, then SOF reissued.
    add(1, 1, 1, 0, 9'h1FF, 0, 1, 0, 8'd2);
    add(1, 0, 0, 0, 9'h1FF, 0, 1, 0, 8'd2);
    add(1, 0, 0, 0, 9'h1FF, 0, 1, 0, 8'd2);
    add(1, 0, 1, 0, 9'h1FF, 0, 1, 0, 8'd2);
    pc = 9'b110100110;
    add(1, 1, pc[0], 0, 9'h1FF, 0, 1, 1, 8'd2);
    for (int k = 1; k < 8; k++) add(1, 0, pc[k], 0, 9'h1FF, 0, 1, 0, 8'd2);
    add(1, 0, pc[8], 0, 9'h1A6, 1, 1, 0, 8'd3);
    add(0, 0, 0, 0, 9'h1A6, 1, 1, 0, 8'd3);

    rst_n = 1'b0;
    pix_valid = 0; pix_sof = 0; pix_in = 0; frame_ack = 0;
    @(negedge clk);
    check("rst_x", 0, 32'(xv), 32'h0);
    check("rst_fv", 0, 32'(frame_valid), 32'h0);
    check("rst_cnt", 0, 32'(frame_cnt), 32'h0);
    check("rst_err", 0, 32'(sync_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rdy", 0, 32'(pix_ready), 32'h1);

    for (int i = 0; i < vecs.size(); i++) begin
      beat(vecs[i].v, vecs[i].s, vecs[i].p, vecs[i].a);
      check("vec_x", i, 32'(xv), 32'(vecs[i].x));
      check("vec_fv", i, 32'(frame_valid), 32'(vecs[i].fv));
      check("vec_rdy", i, 32'(pix_ready), 32'(vecs[i].rdy));
      check("vec_err", i, 32'(sync_err), 32'(vecs[i].err));
      check("vec_cnt", i, 32'(frame_cnt), 32'(vecs[i].cnt));
    end

    // Pixels without SOF after reset are each dropped with an error pulse.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      beat(1, 0, 1, 0);
      check("nosof_err", k, 32'(sync_err), 32'h1);
      check("nosof_fv", k, 32'(frame_valid), 32'h0);
    end
    beat(0, 0, 0, 0);
    check("nosof_err_idle", 0, 32'(sync_err), 32'h0);

    // 256 back-to-back frames with ack tied high: counter wraps, no bubbles.
    do_reset();
    pat = '0;
    for (int f = 0; f < 256; f++) begin
      pat = 9'(f * 37 + 5);
      for (int k = 0; k < 9; k++) begin
        beat(1, k == 0, pat[k], 1);
        check("b2b_rdy", f * 9 + k, 32'(pix_ready), 32'h1);
      end
      if (f == 0 || f == 255) begin
        check("b2b_x", f, 32'(xv), 32'(pat));
        check("b2b_fv", f, 32'(frame_valid), 32'h1);
      end
      if (f == 0) check("b2b_cnt1", f, 32'(frame_cnt), 32'h1);
    end
    check("b2b_wrap", 0, 32'(frame_cnt), 32'h0);

    // Reset mid-frame while a frame is held.
    do_reset();
    pb = 9'h0F5;
    send_frame(pb, 0);
    check("mid_fv", 0, 32'(frame_valid), 32'h1);
    for (int k = 0; k < 5; k++) beat(1, k == 0, 1, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_x", 0, 32'(xv), 32'h0);
    check("mid_rst_fv", 0, 32'(frame_valid), 32'h0);
    check("mid_rst_cnt", 0, 32'(frame_cnt), 32'h0);
    check("mid_rst_rdy", 0, 32'(pix_ready), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pb = 9'h0C3;
    send_frame(pb, 0);
    check("post_x", 0, 32'(xv), 32'h0C3);
    check("post_fv", 0, 32'(frame_valid), 32'h1);
    check("post_cnt", 0, 32'(frame_cnt), 32'h1);
    check("post_err", 0, 32'(sync_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_frame_loader.md
PIXEL_FRAME_LOADER -- requirements
Module: pixel_frame_loader

Interface
REQ-001 SHALL have parameter FRAME_CNT_W, default 8, width of the completed-frame counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pix_in  input  1  serial binary pixel, 0 or 1.
REQ-005 SHALL have port pix_valid  input  1  pix_in/pix_sof are valid this cycle.
REQ-006 SHALL have port pix_sof  input  1  marks the first pixel (X_0) of a 3x3 frame.
REQ-007 SHALL have port pix_ready  output  1  loader accepts a pixel this cycle; beat accepted when pix_valid && pix_ready.
REQ-008 SHALL have ports X_0 .. X_8  output  1 each  held frame pixels, row-major, direct drive of downstream weighted-sum stages.
REQ-009 SHALL have port frame_valid  output  1  X_0..X_8 hold a complete, unconsumed frame.
REQ-010 SHALL have port frame_ack  input  1  downstream consumes the held frame; effective only when frame_valid=1.
REQ-011 SHALL have port frame_cnt  output  FRAME_CNT_W  count of frames transferred to the output registers.
REQ-012 SHALL have port sync_err  output  1  one-cycle pulse on framing violation.

Function
REQ-013 SHALL contain a 9-bit fill buffer, a 4-bit fill index (0..9), a 9-bit output register and a two-state FSM: FILL, FULL.
REQ-014 SHALL drive pix_ready=1 in FILL and pix_ready=0 in FULL.
REQ-015 SHALL, on an accepted beat with pix_sof=1, write pix_in to fill bit 0 and set index to 1, regardless of prior index.
REQ-016 SHALL pulse sync_err for that cycle if an SOF beat is accepted while index is 1..8 (partial frame discarded).
REQ-017 SHALL, on an accepted beat with pix_sof=0 and index 1..8, write pix_in to fill bit [index] and increment index.
REQ-018 SHALL, on an accepted beat with pix_sof=0 and index 0, discard the pixel and pulse sync_err.
REQ-019 SHALL treat the frame as complete on the edge that accepts the 9th pixel (index 8 -> 9).
REQ-020 SHALL, at completion, copy the fill buffer (including the 9th pixel) into the output register on that same edge if frame_valid=0 or frame_ack=1 that cycle, set frame_valid=1, index to 0, stay in FILL.
REQ-021 SHALL, at completion with frame_valid=1 and frame_ack=0, enter FULL, holding fill buffer, index=9.
REQ-022 SHALL, in FULL, transfer fill to output, set index 0 and return to FILL on the first edge where frame_ack=1.
REQ-023 SHALL clear frame_valid on an edge with frame_valid && frame_ack and no transfer; a transfer on the same edge keeps frame_valid=1 with new data.
REQ-024 SHALL keep X_0..X_8 stable while frame_valid=1 and no transfer occurs; fill bit k drives X_k.
REQ-025 SHALL increment frame_cnt by 1 on every transfer, wrapping 2^FRAME_CNT_W-1 -> 0.
REQ-026 SHALL ignore frame_ack when frame_valid=0; no state change, no error.
REQ-027 SHALL provide latency of one edge: 9th pixel accepted on edge N, new X_* and frame_valid visible after edge N.
REQ-028 SHALL sustain one pixel per cycle with frame_ack tied high (no bubbles between frames).

Reset
REQ-029 SHALL, on rst_n=0, asynchronously clear fill buffer, index, output register (X_0..X_8=0), frame_valid=0, frame_cnt=0, sync_err=0, FSM=FILL; pix_ready=1 after reset release.
REQ-030 SHALL discard any partial frame on reset mid-operation; first post-reset beat requires pix_sof=1.

Structure
REQ-031 SHALL place N_PIX=9, IDX_W=4 and the FILL/FULL state encoding in the shared package used by the pixel-path modules.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 SHALL verify: frame 1,0,1,0,1,0,1,0,1 with SOF on first, frame_ack=0 -> after 9th edge X_0..X_8=101010101, frame_valid=1, frame_cnt=1.
REQ-034 SHALL verify: second full frame 111111111 while first held, frame_ack=0 -> pix_ready=0 after 9th pixel, X unchanged; ack pulse -> X=111111111, frame_cnt=2, pix_ready=1.
REQ-035 SHALL verify: SOF reissued after 4 pixels -> sync_err one-cycle pulse, new frame completes 9 beats after the new SOF.
REQ-036 SHALL verify: pixels without SOF after reset -> each discarded with sync_err pulse, frame_valid stays 0.
REQ-037 SHALL verify: 256 back-to-back frames, frame_ack=1, pix_valid=1 -> frame_cnt wraps to 0, pix_ready never drops.
REQ-038 SHALL verify: rst_n asserted after 5 pixels of a frame with frame_valid=1 -> all outputs 0 immediately, next SOF frame loads cleanly.
